rpn_controller: RTL and testbench
=================================

# rpn_controller

Sequencing controller between the numpad decoder and the operand stack of the RPN calculator. It turns raw held-key codes into one-shot stack commands (write/push/pop plus the new top value) and guards stack depth. It runs signed division as a multi-cycle iterative operation, holding `busy` and dropping key events while it runs. It replaces the combinational key-decode logic at top level.

## Interface
- `WIDTH`, 32, operand and stack element width in bits
- `DEPTH`, 32, stack capacity; must be ≤ 63 so it fits the `count` width

- `clock`  in  1  system clock, 50 MHz
- `reset`  in  1  synchronous, active-high
- `key`  in  5  numpad code; bit 4 = pressed, bits 3:0 = key index (digit/op map below)
- `top`  in  WIDTH  current stack top
- `next`  in  WIDTH  element below top
- `count`  in  6  stack element count
- `write`  out  1  one-cycle pulse: stack loads `value` into top
- `push`  out  1  one-cycle pulse: stack pushes
- `pop`  out  1  one-cycle pulse: stack pops
- `value`  out  WIDTH  value for `write`; valid when `write`=1
- `busy`  out  1  high while a command is executing; events are dropped
- `fault`  out  2  sticky status: 00 none, 01 underflow, 10 overflow, 11 divide-by-zero

## Operation
- Key map: 10000=1, 10001=4, 10010=7, 10011=0, 10100=2, 10101=5, 10110=8, 11000=3, 11001=6, 11010=9, 11100=A (push), 11101=B (+), 11110=C (−), 11111=D (×), 11011=E (÷), 10111=F (negate).
- Event detection: `key` is registered every cycle, including while busy. An event is `key[4]`=1 when the previous sample had `key[4]`=0. A held key fires once. Changing from one pressed code to another pressed code fires nothing.
- The event is accepted only in IDLE. Acceptance clears `fault`, then the guard checks run:
  - digits and F need `count` ≥ 1;
  - B/C/D/E need `count` ≥ 2;
  - A needs `count` < `DEPTH`.
  - A failed guard sets `fault` (01 for a low count, 10 for full) and issues no pulses.
- Results, all truncated to the low WIDTH bits, two's complement:
  - digit d: `top`×10+d, write;
  - F: −`top`, write;
  - A: push only;
  - B/C/D: pop+write with `next`+`top`, `next`−`top`, or low half of `next`×`top`.
- E (÷):
  - `top`=0 sets `fault`=11 and issues no pulses.
  - Otherwise run an unsigned restoring divide on magnitudes |`next`| / |`top`|, one quotient bit per cycle.
  - Negate the quotient if the operand sign bits differ. This truncates toward zero.
  - Most-negative ÷ −1 wraps to most-negative.
  - Operands are captured at acceptance; `top` and `next` changing during the divide have no effect.
- States:
  - IDLE → EXEC on an accepted non-E event that passes its guard.
  - IDLE → DIV on an accepted E that passes its guard.
  - EXEC → IDLE.
  - DIV → DIV_DONE after WIDTH iterations.
  - DIV_DONE → IDLE.
- Only one of push, or pop+write, or write is ever asserted in a given cycle.

## Timing
- Reset values: `write`=`push`=`pop`=0, `value`=0, `busy`=0, `fault`=00, state IDLE, key sample register=0. The reset sample of 0 means a key held through reset fires one event after release of reset.
- Reset mid-divide aborts at once: no pulses, back to IDLE.
- Non-E event sampled at cycle t: pulses and `value` are asserted in cycle t+1 for exactly 1 cycle. `busy`=1 in t+1.
- E event at t: `busy`=1 from t+1 to t+WIDTH+1. Iterations run t+1…t+WIDTH. The pop+write pulse is in t+WIDTH+1. `busy` is 0 in t+WIDTH+2.
- A guard failure or divide-by-zero at t updates `fault` at t+1 and leaves `busy` at 0.
- An event landing in a busy cycle is lost.
- Back-to-back events need a release, so the minimum spacing is 2 cycles. `top` has updated before the next event is evaluated.

## Structure
- Package `calc_pkg`:
  - key-code localparams (KEY_0…KEY_9, KEY_PUSH, KEY_ADD, KEY_SUB, KEY_MUL, KEY_DIV, KEY_NEG);
  - fault codes;
  - state enum (IDLE, EXEC, DIV, DIV_DONE).
- One sub-module, `seq_divider`: an unsigned WIDTH-bit restoring divider with `start`, `done`, `dividend`, `divisor`, `quotient`. Sign handling stays in `rpn_controller`.

## Test plan
- `count`=1, `top`=12; press 5 then release → one `write` cycle with `value`=125, `busy` high that cycle only, and no repeat while the key is held.
- `count`=2, `next`=7, `top`=9; press C → pop+write with `value`=0xFFFFFFFE. Then press D with `next`=0x10000, `top`=0x10000 → `value`=0.
- `count`=2, `next`=−7, `top`=2; press E → `busy` for 33 cycles, then pop+write with `value`=−3 in cycle t+33. A key press mid-divide produces no extra pulse.
- `top`=0 on E → `fault`=11, no pulses. `count`=1 on B → `fault`=01. `count`=`DEPTH` on A → `fault`=10. Each fault clears on the next accepted event.
- `next`=0x80000000, `top`=0xFFFFFFFF; press E → `value`=0x80000000.
- Assert `reset` 10 cycles into a divide → all outputs 0 and no pulse. After reset, a fresh press of 0 gives `value`=`top`×10.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared definitions for the RPN calculator: key codes, fault codes, controller states.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package calc_pkg;

  // Numpad codes as seen on the key bus: bit 4 = pressed, bits 3:0 = key index.
  localparam logic [4:0] KEY_1    = 5'b10000;
  localparam logic [4:0] KEY_4    = 5'b10001;
  localparam logic [4:0] KEY_7    = 5'b10010;
  localparam logic [4:0] KEY_0    = 5'b10011;
  localparam logic [4:0] KEY_2    = 5'b10100;
  localparam logic [4:0] KEY_5    = 5'b10101;
  localparam logic [4:0] KEY_8    = 5'b10110;
  localparam logic [4:0] KEY_NEG  = 5'b10111;
  localparam logic [4:0] KEY_3    = 5'b11000;
  localparam logic [4:0] KEY_6    = 5'b11001;
  localparam logic [4:0] KEY_9    = 5'b11010;
  localparam logic [4:0] KEY_DIV  = 5'b11011;
  localparam logic [4:0] KEY_PUSH = 5'b11100;
  localparam logic [4:0] KEY_ADD  = 5'b11101;
  localparam logic [4:0] KEY_SUB  = 5'b11110;
  localparam logic [4:0] KEY_MUL  = 5'b11111;

  localparam logic [1:0] FAULT_NONE  = 2'b00;
  localparam logic [1:0] FAULT_UNDER = 2'b01;
  localparam logic [1:0] FAULT_OVER  = 2'b10;
  localparam logic [1:0] FAULT_DIV0  = 2'b11;

  typedef enum logic [1:0] {IDLE, EXEC, DIV, DIV_DONE} state_t;

  // Which stack pulses an EXEC cycle issues.
  typedef enum logic [1:0] {CMD_WRITE, CMD_PUSH, CMD_POP_WRITE} cmd_t;

  // Decimal value of a digit key; non-digit codes return 0 and are never used as digits.
  function automatic logic [3:0] key_digit(input logic [4:0] code);
    case (code)
      KEY_1:   return 4'd1;
      KEY_2:   return 4'd2;
      KEY_3:   return 4'd3;
      KEY_4:   return 4'd4;
      KEY_5:   return 4'd5;
      KEY_6:   return 4'd6;
      KEY_7:   return 4'd7;
      KEY_8:   return 4'd8;
      KEY_9:   return 4'd9;
      default: return 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/seq_divider.sv
// Unsigned restoring divider, one quotient bit per cycle.
// Latency: WIDTH cycles after start; done is high during the final iteration cycle, quotient valid after it.
// Backpressure: none; a new start restarts the operation, reset aborts it.
// Ports: clock, reset (sync, active-high), start, dividend, divisor -> done, quotient.
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             done,
  output logic [WIDTH-1:0] quotient
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [CW-1:0]    iter_left;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;    // dividend bits shift out the top as quotient bits shift in
  logic [WIDTH-1:0] dsr;
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH:0]   diff;

  always_comb begin
    rem_shift = {rem, quo[WIDTH-1]};
    diff      = rem_shift - {1'b0, dsr};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      iter_left <= '0;
      rem       <= '0;
      quo       <= '0;
      dsr       <= '0;
    end else if (start) begin
      iter_left <= CW'(WIDTH);
      rem       <= '0;
      quo       <= dividend;
      dsr       <= divisor;
    end else if (iter_left != '0) begin
      iter_left <= iter_left - CW'(1);
      if (!diff[WIDTH]) begin
        rem <= diff[WIDTH-1:0];
        quo <= {quo[WIDTH-2:0], 1'b1};
      end else begin
        rem <= rem_shift[WIDTH-1:0];
        quo <= {quo[WIDTH-2:0], 1'b0};
      end
    end
  end

  assign done     = (iter_left == CW'(1));
  assign quotient = quo;

endmodule

// File: rtl/rpn_controller.sv
// Turns held numpad codes into one-shot stack commands, guards stack depth, runs signed divide.
// Latency: 1 cycle for non-divide commands, WIDTH+1 cycles for divide.
// Backpressure: busy high while executing; key events landing in busy cycles are dropped.
// Ports: clock, reset (sync, active-high), key, top, next, count -> write, push, pop, value, busy, fault.
module rpn_controller
  import calc_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [4:0]       key,
  input  logic [WIDTH-1:0] top,
  input  logic [WIDTH-1:0] next,
  input  logic [5:0]       count,
  output logic             write,
  output logic             push,
  output logic             pop,
  output logic [WIDTH-1:0] value,
  output logic             busy,
  output logic [1:0]       fault
);

  state_t           state, state_nxt;
  logic             pressed_q;
  logic             accept;
  cmd_t             cmd_q, cmd_nxt;
  logic [WIDTH-1:0] result_q, result_nxt;
  logic             neg_q;
  logic [1:0]       fault_nxt;
  logic             guard_ok;
  logic             is_div;
  logic             has_one, has_two, has_room;
  logic [WIDTH-1:0] top_mag, next_mag, quotient;
  logic             div_done;

  assign accept   = key[4] && !pressed_q && (state == IDLE);
  assign has_one  = (count >= 6'd1);
  assign has_two  = (count >= 6'd2);
  assign has_room = (count < 6'(DEPTH));
  assign top_mag  = top[WIDTH-1]  ? -top  : top;
  assign next_mag = next[WIDTH-1] ? -next : next;

  // Unsigned core; the sign of the result is applied here from the captured operand signs.
  seq_divider #(.WIDTH(WIDTH)) u_div (
    .clock    (clock),
    .reset    (reset),
    .start    (accept && guard_ok && is_div),
    .dividend (next_mag),
    .divisor  (top_mag),
    .done     (div_done),
    .quotient (quotient)
  );

  // Key decode and guard evaluation, meaningful only in an accepting cycle.
  always_comb begin
    cmd_nxt    = CMD_POP_WRITE;
    result_nxt = '0;
    guard_ok   = has_two;
    fault_nxt  = has_two ? FAULT_NONE : FAULT_UNDER;
    is_div     = 1'b0;
    case (key)
      KEY_PUSH: begin
        cmd_nxt   = CMD_PUSH;
        guard_ok  = has_room;
        fault_nxt = has_room ? FAULT_NONE : FAULT_OVER;
      end
      KEY_ADD: result_nxt = next + top;
      KEY_SUB: result_nxt = next - top;
      KEY_MUL: result_nxt = next * top;
      KEY_DIV: begin
        is_div = 1'b1;
        // Depth is checked before the zero divisor.
        if (has_two && top == '0) begin
          guard_ok  = 1'b0;
          fault_nxt = FAULT_DIV0;
        end
      end
      KEY_NEG: begin
        cmd_nxt    = CMD_WRITE;
        result_nxt = -top;
        guard_ok   = has_one;
        fault_nxt  = has_one ? FAULT_NONE : FAULT_UNDER;
      end
      default: begin
        cmd_nxt    = CMD_WRITE;
        result_nxt = top * WIDTH'(10) + WIDTH'(key_digit(key));
        guard_ok   = has_one;
        fault_nxt  = has_one ? FAULT_NONE : FAULT_UNDER;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    write     = 1'b0;
    push      = 1'b0;
    pop       = 1'b0;
    value     = '0;
    case (state)
      IDLE: if (accept && guard_ok) state_nxt = is_div ? DIV : EXEC;
      EXEC: begin
        state_nxt = IDLE;
        push      = (cmd_q == CMD_PUSH);
        pop       = (cmd_q == CMD_POP_WRITE);
        write     = (cmd_q != CMD_PUSH);
        value     = (cmd_q != CMD_PUSH) ? result_q : '0;
      end
      DIV: if (div_done) state_nxt = DIV_DONE;
      DIV_DONE: begin
        state_nxt = IDLE;
        pop       = 1'b1;
        write     = 1'b1;
        value     = neg_q ? -quotient : quotient;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  // The key sample is taken every cycle so a key held through busy does not fire later.
  always_ff @(posedge clock) begin
    if (reset) begin
      pressed_q <= 1'b0;
      fault     <= FAULT_NONE;
      cmd_q     <= CMD_WRITE;
      result_q  <= '0;
      neg_q     <= 1'b0;
    end else begin
      pressed_q <= key[4];
      if (accept) begin
        fault    <= fault_nxt;
        cmd_q    <= cmd_nxt;
        result_q <= result_nxt;
        neg_q    <= next[WIDTH-1] ^ top[WIDTH-1];
      end
    end
  end

endmodule

// File: tb/tb_rpn_controller.sv
// Self-checking bench for rpn_controller: timeline model plus directed literal checks.
module tb_rpn_controller;

  localparam int W = 32;
  localparam int D = 32;

  logic         clock;
  logic         reset;
  logic [4:0]   key;
  logic [W-1:0] top;
  logic [W-1:0] next;
  logic [5:0]   count;
  logic         write;
  logic         push;
  logic         pop;
  logic [W-1:0] value;
  logic         busy;
  logic [1:0]   fault;

  rpn_controller #(.WIDTH(W), .DEPTH(D)) dut (
    .clock (clock),
    .reset (reset),
    .key   (key),
    .top   (top),
    .next  (next),
    .count (count),
    .write (write),
    .push  (push),
    .pop   (pop),
    .value (value),
    .busy  (busy),
    .fault (fault)
  );

  initial clock = 1'b0;
  always #10 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- model: a timeline of busy windows and scheduled pulses ----------------
  int          cyc       = 0;
  int          busy_end  = -1;
  int          pulse_cyc = -1;
  int          m_t;
  logic        m_prev    = 1'b0;
  logic [1:0]  m_fault   = 2'b00;
  logic        p_write   = 1'b0;
  logic        p_push    = 1'b0;
  logic        p_pop     = 1'b0;
  logic [31:0] p_val     = '0;
  logic        exp_busy  = 1'b0;
  logic        exp_hit   = 1'b0;

  function automatic int digit_of(input logic [3:0] idx);
    case (idx)
      4'd0: return 1;  4'd1: return 4;  4'd2: return 7;  4'd3: return 0;
      4'd4: return 2;  4'd5: return 5;  4'd6: return 8;  4'd8: return 3;
      4'd9: return 6;  4'd10: return 9;
      default: return 0;
    endcase
  endfunction

  function automatic logic [31:0] model_div(input logic [31:0] n, input logic [31:0] d);
    longint a;
    longint b;
    longint q;
    a = longint'($signed(n));
    b = longint'($signed(d));
    q = a / b;
    return 32'(q);
  endfunction

  task automatic accept_event(input int t);
    logic [31:0] r;
    int need;
    bit is_push;
    bit is_div;
    need = 1; is_push = 0; is_div = 0; r = '0;
    case (key[3:0])
      4'b1100: is_push = 1;
      4'b1101: begin need = 2; r = next + top; end
      4'b1110: begin need = 2; r = next - top; end
      4'b1111: begin need = 2; r = next * top; end
      4'b1011: begin need = 2; is_div = 1; end
      4'b0111: r = 32'(0) - top;
      default: r = 32'(top * 32'd10 + 32'(digit_of(key[3:0])));
    endcase
    if (is_push && int'(count) >= D)        m_fault = 2'b10;
    else if (!is_push && int'(count) < need) m_fault = 2'b01;
    else if (is_div && top == 0)             m_fault = 2'b11;
    else begin
      m_fault   = 2'b00;
      busy_end  = is_div ? t + W + 1 : t + 1;
      pulse_cyc = busy_end;
      p_push    = is_push;
      p_pop     = (need == 2);
      p_write   = !is_push;
      p_val     = is_div ? model_div(next, top) : r;
    end
  endtask

  // During cycle c, cyc == c; inputs seen at the edge ending cycle t drive cycle t+1.
  always @(posedge clock) begin
    m_t = cyc;
    cyc = cyc + 1;
    if (reset) begin
      m_prev    = 1'b0;
      m_fault   = 2'b00;
      busy_end  = m_t;
      pulse_cyc = -1;
    end else begin
      if (key[4] && !m_prev && m_t > busy_end) accept_event(m_t);
      m_prev = key[4];
    end
    exp_busy = (cyc <= busy_end);
    exp_hit  = (cyc == pulse_cyc);
  end

  // ---------------- per-cycle compare and activity log ----------------
  int          n_write = 0, n_push = 0, n_pop = 0, n_busy = 0;
  int          last_write_cyc = -1;
  logic [31:0] last_value = '0;

  always @(negedge clock) begin
    if (cyc >= 1) begin
      check("write", write, exp_hit && p_write);
      check("push",  push,  exp_hit && p_push);
      check("pop",   pop,   exp_hit && p_pop);
      check("busy",  busy,  exp_busy);
      check("fault", fault, m_fault);
      if (exp_hit && p_write) check("value", value, p_val);
      if (write) begin n_write++; last_value = value; last_write_cyc = cyc; end
      if (push) n_push++;
      if (pop)  n_pop++;
      if (busy) n_busy++;
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic press(input logic [4:0] code, input int hold);
    key = code;
    tick(hold);
    key = 5'b0;
    tick(3);
  endtask

  task automatic wait_write(input int w0, input int budget);
    for (int i = 0; i < budget && n_write == w0; i++) tick(1);
    tick(4);
  endtask

  int w0, p0, o0, b0, t0;

  initial begin
    reset = 1'b1; key = 5'b0; top = '0; next = '0; count = '0;
    tick(3);
    check("rst_write", write, 0);
    check("rst_push",  push,  0);
    check("rst_pop",   pop,   0);
    check("rst_value", value, 0);
    check("rst_busy",  busy,  0);
    check("rst_fault", fault, 0);
    reset = 1'b0;
    tick(2);

    // digit 5 held for several cycles: fires once
    count = 6'd1; top = 32'd12;
    w0 = n_write; b0 = n_busy;
    press(5'b10101, 5);
    check("d5_writes", n_write - w0, 1);
    check("d5_value",  last_value, 32'd125);
    check("d5_busy",   n_busy - b0, 1);

    // subtract and multiply
    count = 6'd2; next = 32'd7; top = 32'd9;
    w0 = n_write; o0 = n_pop;
    press(5'b11110, 2);
    check("sub_value", last_value, 32'hFFFF_FFFE);
    check("sub_pops",  n_pop - o0, 1);
    check("sub_writes", n_write - w0, 1);
    next = 32'h10000; top = 32'h10000;
    w0 = n_write;
    press(5'b11111, 2);
    check("mul_writes", n_write - w0, 1);
    check("mul_value",  last_value, 32'd0);

    // signed divide -7 / 2 with a dropped press in the middle
    next = 32'hFFFF_FFF9; top = 32'd2;
    w0 = n_write; o0 = n_pop; p0 = n_push; b0 = n_busy;
    t0 = cyc;
    key = 5'b11011; tick(1); key = 5'b0; tick(9);
    key = 5'b10000; tick(2); key = 5'b0;
    wait_write(w0, 60);
    tick(4);
    check("div_writes",  n_write - w0, 1);
    check("div_pops",    n_pop - o0, 1);
    check("div_pushes",  n_push - p0, 0);
    check("div_value",   last_value, 32'hFFFF_FFFD);
    check("div_latency", last_write_cyc - t0, 33);
    check("div_busy",    n_busy - b0, 33);

    // divide by zero
    top = 32'd0;
    w0 = n_write; b0 = n_busy;
    press(5'b11011, 2);
    check("div0_fault",  fault, 2'b11);
    check("div0_writes", n_write - w0, 0);
    check("div0_busy",   n_busy - b0, 0);

    // underflow on add clears the previous fault
    count = 6'd1; top = 32'd1; next = 32'd1;
    press(5'b11101, 2);
    check("under_fault", fault, 2'b01);

    // overflow on push, then a legal push clears it
    count = 6'd32;
    p0 = n_push;
    press(5'b11100, 2);
    check("over_fault",  fault, 2'b10);
    check("over_pushes", n_push - p0, 0);
    count = 6'd5;
    press(5'b11100, 2);
    check("push_pushes", n_push - p0, 1);
    check("push_fault",  fault, 2'b00);

    // most-negative / -1 wraps
    count = 6'd2; next = 32'h8000_0000; top = 32'hFFFF_FFFF;
    w0 = n_write;
    press(5'b11011, 1);
    wait_write(w0, 60);
    check("wrap_value", last_value, 32'h8000_0000);

    // switching from one pressed code to another does not fire
    count = 6'd1; top = 32'd3;
    w0 = n_write;
    key = 5'b10000; tick(2); key = 5'b10100; tick(2);
    key = 5'b0; tick(3);
    check("switch_writes", n_write - w0, 1);
    check("switch_value",  last_value, 32'd31);

    // minimum spacing of two cycles between events
    top = 32'd0;
    w0 = n_write;
    key = 5'b10010; tick(1); key = 5'b0; tick(1);
    key = 5'b10110; tick(1); key = 5'b0; tick(3);
    check("b2b_writes", n_write - w0, 2);
    check("b2b_value",  last_value, 32'd8);

    // reset ten cycles into a divide aborts it
    count = 6'd2; next = 32'd100; top = 32'd3;
    key = 5'b11011; tick(1); key = 5'b0; tick(9);
    reset = 1'b1; tick(1);
    check("abort_write", write, 0);
    check("abort_pop",   pop,   0);
    check("abort_value", value, 0);
    check("abort_busy",  busy,  0);
    check("abort_fault", fault, 0);
    reset = 1'b0;
    w0 = n_write;
    tick(40);
    check("abort_writes", n_write - w0, 0);
    count = 6'd1; top = 32'd17;
    press(5'b10011, 2);
    check("after_writes", n_write - w0, 1);
    check("after_value",  last_value, 32'd170);

    tick(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
